ace_line_state_tracker: RTL and testbench

Parametrised successor to the single-line 3-state ACE FSM.
- Tracks coherence state for NUM_LINES cache lines using five states: I, UC, UD, SC, SD.
- Arbitrates local read/write requests against incoming snoops.
- Runs the AC/CR snoop handshake with ACE CRRESP encoding.
- Emits per-access memory/cache action pulses tagged with the line index.
- Sits between the local cache controller and the interconnect snoop channel.

---
 rtl/ace_line_pkg.sv | 37 +++
 rtl/ace_snoop_resp_lut.sv | 67 ++++++
 rtl/ace_line_state_tracker.sv | 185 ++++++++++++++++++
 tb/tb_ace_line_state_tracker.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ace_line_pkg.sv
// Shared definitions for the ACE multi-line coherence tracker:
// line-state encodings, snoop opcodes, CRRESP bit positions and
// the control FSM state type.
package ace_line_pkg;

    localparam logic [2:0] ST_I  = 3'd0;
    localparam logic [2:0] ST_UC = 3'd1;
    localparam logic [2:0] ST_UD = 3'd2;
    localparam logic [2:0] ST_SC = 3'd3;
    localparam logic [2:0] ST_SD = 3'd4;

    localparam logic [1:0] SNP_RS = 2'd0;
    localparam logic [1:0] SNP_RU = 2'd1;
    localparam logic [1:0] SNP_CI = 2'd2;
    localparam logic [1:0] SNP_MI = 2'd3;

    localparam int CR_DT  = 0;
    localparam int CR_ERR = 1;
    localparam int CR_PD  = 2;
    localparam int CR_IS  = 3;
    localparam int CR_WU  = 4;

    typedef enum logic [0:0] {
        CTL_IDLE = 1'b0,
        CTL_RESP = 1'b1
    } ctl_state_t;

    // Encodings above ST_SD are not legal line states; they read as Invalid.
    function automatic logic [2:0] norm_state(input logic [2:0] s);
        if (s > ST_SD) begin
            return ST_I;
        end else begin
            return s;
        end
    endfunction

endpackage

// File: rtl/ace_snoop_resp_lut.sv
// Combinational snoop lookup: (current line state, snoop opcode) ->
// next line state, CRRESP value and writeback request.
module ace_snoop_resp_lut
    import ace_line_pkg::*;
(
    input  logic [2:0] cur_state,
    input  logic [1:0] snoop,
    output logic [2:0] next_state,
    output logic [4:0] crresp,
    output logic       wb_req
);

    logic [2:0] st_s;

    assign st_s = norm_state(cur_state);

    // Snoop transition table; CRRESP literals are {WU, IS, PD, ERR, DT}.
    always_comb begin
        next_state = ST_I;
        crresp     = 5'b00000;
        wb_req     = 1'b0;
        case (snoop)
            SNP_RS: begin
                case (st_s)
                    ST_UC: begin next_state = ST_SC; crresp = 5'b11001; end
                    ST_UD: begin next_state = ST_SD; crresp = 5'b11001; end
                    ST_SC: begin next_state = ST_SC; crresp = 5'b01000; end
                    ST_SD: begin next_state = ST_SD; crresp = 5'b01001; end
                    default: begin next_state = ST_I; crresp = 5'b00000; end
                endcase
            end
            SNP_RU: begin
                case (st_s)
                    ST_UC:   crresp = 5'b10001;
                    ST_UD:   crresp = 5'b10101;
                    ST_SD:   crresp = 5'b00101;
                    default: crresp = 5'b00000;
                endcase
            end
            SNP_CI: begin
                if ((st_s == ST_UC) || (st_s == ST_UD)) begin
                    crresp = 5'b10000;
                end else begin
                    crresp = 5'b00000;
                end
                if ((st_s == ST_UD) || (st_s == ST_SD)) begin
                    wb_req = 1'b1;
                end else begin
                    wb_req = 1'b0;
                end
            end
            SNP_MI: begin
                if ((st_s == ST_UC) || (st_s == ST_UD)) begin
                    crresp = 5'b10000;
                end else begin
                    crresp = 5'b00000;
                end
            end
            default: begin
                next_state = ST_I;
                crresp     = 5'b00000;
                wb_req     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ace_line_state_tracker.sv
// Five-state (I/UC/UD/SC/SD) coherence tracker for 2**IDX_W lines.
// Arbitrates local requests against AC snoops (snoops win), runs the
// CR response handshake and emits index-tagged action pulses.
// Optional ACE_STATS_EN adds saturating snoop data-transfer and
// writeback counters.
module ace_line_state_tracker
    import ace_line_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [IDX_W-1:0] req_idx,
    input  logic             acvalid,
    output logic             acready,
    input  logic [1:0]       acsnoop,
    input  logic [IDX_W-1:0] acidx,
    output logic             crvalid,
    input  logic             crready,
    output logic [4:0]       crresp,
    output logic             write_main_mem,
    output logic             write_cache,
    output logic             read_main_mem,
    output logic             read_cache,
    output logic [IDX_W-1:0] act_idx,
    input  logic [IDX_W-1:0] query_idx,
    output logic [2:0]       query_state
`ifdef ACE_STATS_EN
    ,
    output logic [15:0]      snoop_dt_cnt,
    output logic [15:0]      wb_cnt
`endif
);

    localparam int NUM_LINES = 1 << IDX_W;

    ctl_state_t       ctl_r;
    ctl_state_t       ctl_nxt_s;
    logic [2:0]       lines_r [NUM_LINES];
    logic             crvalid_r;
    logic [4:0]       crresp_r;
    logic             wmm_r;
    logic             wc_r;
    logic             rmm_r;
    logic             rc_r;
    logic [IDX_W-1:0] act_idx_r;

    logic             snoop_fire_s;
    logic             req_fire_s;
    logic [2:0]       req_cur_s;
    logic [2:0]       lut_next_s;
    logic [4:0]       lut_resp_s;
    logic             lut_wb_s;

    assign acready      = (ctl_r == CTL_IDLE);
    assign req_ready    = (ctl_r == CTL_IDLE) && !acvalid;
    assign snoop_fire_s = (ctl_r == CTL_IDLE) && acvalid;
    assign req_fire_s   = (ctl_r == CTL_IDLE) && !acvalid && req_valid;
    assign req_cur_s    = norm_state(lines_r[req_idx]);

    ace_snoop_resp_lut u_lut (
        .cur_state  (lines_r[acidx]),
        .snoop      (acsnoop),
        .next_state (lut_next_s),
        .crresp     (lut_resp_s),
        .wb_req     (lut_wb_s)
    );

    // Control FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_r <= CTL_IDLE;
        end else begin
            ctl_r <= ctl_nxt_s;
        end
    end

    // Control FSM next state: an accepted snoop holds us in RESP until CR handshake.
    always_comb begin
        ctl_nxt_s = ctl_r;
        case (ctl_r)
            CTL_IDLE: begin
                if (acvalid) begin
                    ctl_nxt_s = CTL_RESP;
                end else begin
                    ctl_nxt_s = CTL_IDLE;
                end
            end
            CTL_RESP: begin
                if (crvalid_r && crready) begin
                    ctl_nxt_s = CTL_IDLE;
                end else begin
                    ctl_nxt_s = CTL_RESP;
                end
            end
            default: ctl_nxt_s = CTL_IDLE;
        endcase
    end

    // Line array, CR response registers and one-cycle action pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                lines_r[i] <= ST_I;
            end
            crvalid_r <= 1'b0;
            crresp_r  <= 5'b00000;
            wmm_r     <= 1'b0;
            wc_r      <= 1'b0;
            rmm_r     <= 1'b0;
            rc_r      <= 1'b0;
            act_idx_r <= '0;
        end else begin
            wmm_r <= 1'b0;
            wc_r  <= 1'b0;
            rmm_r <= 1'b0;
            rc_r  <= 1'b0;
            if (snoop_fire_s) begin
                lines_r[acidx] <= lut_next_s;
                crvalid_r      <= 1'b1;
                crresp_r       <= lut_resp_s;
                wmm_r          <= lut_wb_s;
                act_idx_r      <= acidx;
            end else if (req_fire_s) begin
                act_idx_r <= req_idx;
                if (req_write) begin
                    lines_r[req_idx] <= ST_UD;
                    wc_r             <= 1'b1;
                    rmm_r            <= (req_cur_s == ST_I);
                end else if (req_cur_s == ST_I) begin
                    lines_r[req_idx] <= ST_UC;
                    rmm_r            <= 1'b1;
                end else begin
                    rc_r <= 1'b1;
                end
            end else if (crvalid_r && crready) begin
                crvalid_r <= 1'b0;
                crresp_r  <= 5'b00000;
            end else begin
                crvalid_r <= crvalid_r;
            end
        end
    end

    assign crvalid        = crvalid_r;
    assign crresp         = crresp_r;
    assign write_main_mem = wmm_r;
    assign write_cache    = wc_r;
    assign read_main_mem  = rmm_r;
    assign read_cache     = rc_r;
    assign act_idx        = act_idx_r;
    assign query_state    = lines_r[query_idx];

`ifdef ACE_STATS_EN
    logic [15:0] dt_cnt_r;
    logic [15:0] wb_cnt_r;

    // Saturating counters; both advance on the snoop-accept edge so they
    // line up with crvalid and the write_main_mem pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dt_cnt_r <= 16'h0000;
            wb_cnt_r <= 16'h0000;
        end else begin
            if (snoop_fire_s && lut_resp_s[CR_DT] && (dt_cnt_r != 16'hFFFF)) begin
                dt_cnt_r <= dt_cnt_r + 16'h0001;
            end else begin
                dt_cnt_r <= dt_cnt_r;
            end
            if (snoop_fire_s && lut_wb_s && (wb_cnt_r != 16'hFFFF)) begin
                wb_cnt_r <= wb_cnt_r + 16'h0001;
            end else begin
                wb_cnt_r <= wb_cnt_r;
            end
        end
    end

    assign snoop_dt_cnt = dt_cnt_r;
    assign wb_cnt       = wb_cnt_r;
`endif

endmodule

// File: tb/tb_ace_line_state_tracker.sv
// Self-checking bench for ace_line_state_tracker: directed scenarios
// followed by randomized traffic, all checked against a rule-based
// reference model of the line states and snoop responses.
module tb_ace_line_state_tracker;

    localparam logic [2:0] S_I  = 3'd0;
    localparam logic [2:0] S_UC = 3'd1;
    localparam logic [2:0] S_UD = 3'd2;
    localparam logic [2:0] S_SC = 3'd3;
    localparam logic [2:0] S_SD = 3'd4;
    localparam logic [1:0] OP_RS = 2'd0;
    localparam logic [1:0] OP_RU = 2'd1;
    localparam logic [1:0] OP_CI = 2'd2;
    localparam logic [1:0] OP_MI = 2'd3;

    logic       clk;
    logic       rst_n;
    logic       req_valid, req_ready, req_write;
    logic [2:0] req_idx;
    logic       acvalid, acready;
    logic [1:0] acsnoop;
    logic [2:0] acidx;
    logic       crvalid, crready;
    logic [4:0] crresp;
    logic       write_main_mem, write_cache, read_main_mem, read_cache;
    logic [2:0] act_idx;
    logic [2:0] query_idx;
    logic [2:0] query_state;
`ifdef ACE_STATS_EN
    logic [15:0] snoop_dt_cnt;
    logic [15:0] wb_cnt;
`endif

    ace_line_state_tracker #(.IDX_W(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_idx        (req_idx),
        .acvalid        (acvalid),
        .acready        (acready),
        .acsnoop        (acsnoop),
        .acidx          (acidx),
        .crvalid        (crvalid),
        .crready        (crready),
        .crresp         (crresp),
        .write_main_mem (write_main_mem),
        .write_cache    (write_cache),
        .read_main_mem  (read_main_mem),
        .read_cache     (read_cache),
        .act_idx        (act_idx),
        .query_idx      (query_idx),
        .query_state    (query_state)
`ifdef ACE_STATS_EN
        ,
        .snoop_dt_cnt   (snoop_dt_cnt),
        .wb_cnt         (wb_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         chk_cnt = 0;
    int         err_cnt = 0;
    logic [2:0] model_st [8];
    bit         busy;
    logic [4:0] held_resp;
    int         exp_dt;
    int         exp_wb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Snoop response derived from the line's properties rather than a table.
    function automatic void snoop_ref(input logic [2:0] s, input logic [1:0] op,
                                      output logic [2:0] ns, output logic [4:0] rsp,
                                      output logic wb);
        bit valid;
        bit uniq;
        bit dirty;
        valid = (s != S_I);
        uniq  = (s == S_UC) || (s == S_UD);
        dirty = (s == S_UD) || (s == S_SD);
        ns    = S_I;
        rsp   = 5'b00000;
        wb    = 1'b0;
        if (op == OP_RS) begin
            ns = !valid ? S_I : (dirty ? S_SD : S_SC);
            if (valid) rsp = {uniq, 1'b1, 1'b0, 1'b0, uniq | dirty};
        end else if (op == OP_RU) begin
            rsp = {uniq, 1'b0, dirty, 1'b0, uniq | dirty};
        end else begin
            rsp = {uniq, 4'b0000};
            wb  = dirty && (op == OP_CI);
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model_st[i] = S_I;
        busy = 1'b0;
        held_resp = 5'b00000;
        exp_dt = 0;
        exp_wb = 0;
    endtask

    // One clock: drive inputs, predict, clock, compare.
    task automatic step(input bit rv, input bit rw, input logic [2:0] ri,
                        input bit av, input logic [1:0] op, input logic [2:0] ai,
                        input bit cr);
        logic [2:0] ns;
        logic [4:0] rsp;
        logic       wb;
        bit         e_rmm, e_wc, e_rc, e_wmm, e_crv;
        logic [4:0] e_rsp;
        logic [2:0] touched;
        req_valid = rv; req_write = rw; req_idx = ri;
        acvalid = av; acsnoop = op; acidx = ai; crready = cr;
        #1;
        check("acready", acready, !busy);
        check("req_ready", req_ready, !busy && !av);
        e_rmm = 0; e_wc = 0; e_rc = 0; e_wmm = 0; e_crv = 0;
        e_rsp = 5'b00000; touched = ri;
        if (busy) begin
            e_crv = !cr;
            e_rsp = held_resp;
            if (cr) busy = 1'b0;
        end else if (av) begin
            snoop_ref(model_st[ai], op, ns, rsp, wb);
            model_st[ai] = ns;
            busy = 1'b1;
            held_resp = rsp;
            e_crv = 1'b1;
            e_rsp = rsp;
            e_wmm = wb;
            touched = ai;
            if (wb) exp_wb++;
            if (rsp[0]) exp_dt++;
        end else if (rv) begin
            e_rmm = (model_st[ri] == S_I);
            e_wc  = rw;
            e_rc  = !rw && (model_st[ri] != S_I);
            if (rw) model_st[ri] = S_UD;
            else if (model_st[ri] == S_I) model_st[ri] = S_UC;
        end
        @(posedge clk);
        @(negedge clk);
        check("crvalid", crvalid, e_crv);
        if (e_crv) check("crresp", crresp, e_rsp);
        check("read_main_mem", read_main_mem, e_rmm);
        check("write_cache", write_cache, e_wc);
        check("read_cache", read_cache, e_rc);
        check("write_main_mem", write_main_mem, e_wmm);
        if (e_rmm || e_wc || e_rc || e_wmm) check("act_idx", act_idx, touched);
        query_idx = touched;
        #1;
        check("query_state", query_state, model_st[touched]);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 0; req_write = 0; req_idx = 3'd0;
        acvalid = 0; acsnoop = 2'd0; acidx = 3'd0; crready = 0; query_idx = 3'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_crvalid", crvalid, 1'b0);
        check("rst_crresp", crresp, 5'b00000);
        check("rst_pulses", {write_main_mem, write_cache, read_main_mem, read_cache}, 4'b0000);
        check("rst_act_idx", act_idx, 3'd0);
        for (int i = 0; i < 8; i++) begin
            query_idx = 3'(i);
            #1;
            check("rst_query", query_state, S_I);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Read fill, then read hit.
        step(1, 0, 3'd2, 0, OP_RS, 3'd0, 0);
        check("t1_state_uc", query_state, S_UC);
        step(1, 0, 3'd2, 0, OP_RS, 3'd0, 0);
        check("t1_read_cache", read_cache, 1'b1);

        // Write miss, then ReadShared.
        step(1, 1, 3'd5, 0, OP_RS, 3'd0, 0);
        check("t2_state_ud", query_state, S_UD);
        step(0, 0, 3'd0, 1, OP_RS, 3'd5, 0);
        check("t2_crresp", crresp, 5'b11001);
        check("t2_state_sd", query_state, S_SD);
        step(0, 0, 3'd0, 0, OP_RS, 3'd0, 1);

        // CleanInvalid of SD line with crready stalled.
        step(0, 0, 3'd0, 1, OP_CI, 3'd5, 0);
        check("t3_wmm", write_main_mem, 1'b1);
        check("t3_act_idx", act_idx, 3'd5);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 3'd4, 0, OP_RS, 3'd0, 0);
            check("t3_crresp_held", crresp, 5'b00000);
        end
        step(0, 0, 3'd0, 0, OP_RS, 3'd0, 1);
        query_idx = 3'd5;
        #1;
        check("t3_state_i", query_state, S_I);

        // Snoop/request collision.
        step(1, 1, 3'd1, 0, OP_RS, 3'd0, 0);
        step(1, 0, 3'd3, 1, OP_RU, 3'd1, 0);
        check("t4_crresp", crresp, 5'b10101);
        step(1, 0, 3'd3, 0, OP_RS, 3'd0, 1);
        step(1, 0, 3'd3, 0, OP_RS, 3'd0, 0);
        check("t4_req_after", read_main_mem, 1'b1);

        // Reset while a response is pending.
        step(0, 0, 3'd0, 1, OP_RS, 3'd2, 0);
        check("t5_crvalid_pre", crvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_crvalid_drop", crvalid, 1'b0);
        model_reset();
        for (int i = 0; i < 8; i++) begin
            query_idx = 3'(i);
            #1;
            check("t5_query", query_state, S_I);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 3'd0, 0, OP_RS, 3'd0, 0);
        step(0, 0, 3'd0, 0, OP_RS, 3'd0, 1);

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), $urandom_range(0, 1));
        end
        step(0, 0, 3'd0, 0, OP_RS, 3'd0, 1);
        step(0, 0, 3'd0, 0, OP_RS, 3'd0, 1);

`ifdef ACE_STATS_EN
        check("stats_dt", snoop_dt_cnt, exp_dt);
        check("stats_wb", wb_cnt, exp_wb);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
